pea_sum_collector: RTL

Parametrised output gatherer for the 3x3 PE array. It accepts per-column partial-sum results (one independent valid per column) into per-column FIFOs. It drains them into a single ready/valid OFM stream in tile order: per output channel, column 0 rows 0..TILE_LEN-1, then column 1, and so on. It sits between the conv2d_3x3 sum/sum_valid outputs and the OFM write-back path, applies upstream backpressure, and flags overflow.

---
 rtl/pea_sum_collector_if.sv | 31 +++
 rtl/pea_sum_collector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pea_sum_collector_if.sv
// Sum-input and OFM-stream bundle between the PE array, the collector and write-back.
// slave = collector side; master = PE array / write-back side.
interface pea_sum_collector_if #(
    parameter int COL       = 8,
    parameter int OFM_WIDTH = 25,
    parameter int CHN_WIDTH = 10,
    parameter int TILE_LEN  = 8
);
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam int RW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;

    logic [COL*OFM_WIDTH-1:0]     sum;
    logic [COL-1:0]               sum_valid;
    logic                         stall_req;
    logic signed [OFM_WIDTH-1:0]  ofm_data;
    logic [CHN_WIDTH-1:0]         ofm_oc;
    logic [CW-1:0]                ofm_col;
    logic [RW-1:0]                ofm_row;
    logic                         ofm_last;
    logic                         ofm_valid;
    logic                         ofm_ready;

    modport slave (
        input  sum, sum_valid, ofm_ready,
        output stall_req, ofm_data, ofm_oc, ofm_col, ofm_row, ofm_last, ofm_valid
    );
    modport master (
        output sum, sum_valid, ofm_ready,
        input  stall_req, ofm_data, ofm_oc, ofm_col, ofm_row, ofm_last, ofm_valid
    );
endinterface

// File: rtl/pea_sum_collector.sv
// Gathers per-column PE sums into per-lane FIFOs and drains them as one OFM
// stream in tile order (oc -> col -> row), with upstream stall and overflow flags.
module pea_sum_collector #(
    parameter int COL          = 8,
    parameter int OFM_WIDTH    = 25,
    parameter int TILE_LEN     = 8,
    parameter int DEPTH        = 16,
    parameter int CHN_WIDTH    = 10,
    parameter int TILE_WIDTH   = 12,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic                   start,
    input  logic [CHN_WIDTH-1:0]   cfg_co,
    input  logic [TILE_WIDTH-1:0]  cfg_tiles,
    pea_sum_collector_if.slave     s,
    output logic                   busy,
    output logic                   collect_done,
    output logic [COL-1:0]         ovf_err
);
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam int RW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(DEPTH - AFULL_MARGIN);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

    logic [COL-1:0]                lane_empty, lane_afull_d, lane_rd;
    logic [COL-1:0][OFM_WIDTH-1:0] lane_rdata;

    // ---------------- per-lane FIFOs ----------------
    for (genvar i = 0; i < COL; i++) begin : g_lane
        logic [OFM_WIDTH-1:0] mem_q [DEPTH];
        logic [AW-1:0]        wptr_q, rptr_q;
        logic [AW:0]          cnt_q, cnt_d;
        logic                 full, do_wr, do_rd, ovf_q;

        assign full  = (cnt_q == FULL_CNT);
        assign do_rd = lane_rd[i] && (cnt_q != '0);
        // a pop on the same edge frees the slot, so a full FIFO still accepts
        assign do_wr = s.sum_valid[i] && (!full || do_rd);

        always_comb begin
            cnt_d = cnt_q;
            if (do_wr && !do_rd)      cnt_d = cnt_q + 1'b1;
            else if (!do_wr && do_rd) cnt_d = cnt_q - 1'b1;
        end

        assign lane_empty[i]   = (cnt_q == '0);
        assign lane_afull_d[i] = (cnt_d >= AFULL_CNT);
        assign lane_rdata[i]   = mem_q[rptr_q];
        assign ovf_err[i]      = ovf_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                ovf_q  <= 1'b0;
            end else if (clr) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (do_wr) wptr_q <= wptr_q + 1'b1;
                if (do_rd) rptr_q <= rptr_q + 1'b1;
                cnt_q <= cnt_d;
                if (s.sum_valid[i] && !do_wr) ovf_q <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (do_wr && !clr) mem_q[wptr_q] <= s.sum[i*OFM_WIDTH +: OFM_WIDTH];
        end
    end

    // ---------------- drain sequencer + output register ----------------
    state_t                       state_q;
    logic [RW-1:0]                row_q, ofm_row_q;
    logic [CW-1:0]                col_q, ofm_col_q;
    logic [CHN_WIDTH-1:0]         oc_q, co_q, ofm_oc_q;
    logic [TILE_WIDTH-1:0]        tile_q, tiles_q;
    logic signed [OFM_WIDTH-1:0]  ofm_data_q;
    logic                         ofm_valid_q, ofm_last_q, done_q, stall_q;
    logic                         load, row_end, col_end, oc_end, tile_end, last_d;

    assign row_end  = (row_q == RW'(TILE_LEN - 1));
    assign col_end  = (col_q == CW'(COL - 1));
    assign oc_end   = (oc_q == co_q - 1'b1);
    assign tile_end = (tile_q == tiles_q - 1'b1);
    assign last_d   = row_end && col_end && oc_end;
    assign load     = (state_q == DRAIN) && (!ofm_valid_q || s.ofm_ready) && !lane_empty[col_q];

    always_comb begin
        lane_rd        = '0;
        lane_rd[col_q] = load;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            oc_q        <= '0;
            tile_q      <= '0;
            co_q        <= '0;
            tiles_q     <= '0;
            ofm_data_q  <= '0;
            ofm_oc_q    <= '0;
            ofm_col_q   <= '0;
            ofm_row_q   <= '0;
            ofm_last_q  <= 1'b0;
            ofm_valid_q <= 1'b0;
            done_q      <= 1'b0;
            stall_q     <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            oc_q        <= '0;
            tile_q      <= '0;
            co_q        <= '0;
            tiles_q     <= '0;
            ofm_data_q  <= '0;
            ofm_oc_q    <= '0;
            ofm_col_q   <= '0;
            ofm_row_q   <= '0;
            ofm_last_q  <= 1'b0;
            ofm_valid_q <= 1'b0;
            done_q      <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            stall_q <= |lane_afull_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    co_q    <= (cfg_co == '0) ? CHN_WIDTH'(1) : cfg_co;
                    tiles_q <= (cfg_tiles == '0) ? TILE_WIDTH'(1) : cfg_tiles;
                    row_q   <= '0;
                    col_q   <= '0;
                    oc_q    <= '0;
                    tile_q  <= '0;
                    state_q <= DRAIN;
                end
                DRAIN: begin
                    if (load) begin
                        ofm_valid_q <= 1'b1;
                        ofm_data_q  <= lane_rdata[col_q];
                        ofm_oc_q    <= oc_q;
                        ofm_col_q   <= col_q;
                        ofm_row_q   <= row_q;
                        ofm_last_q  <= last_d;
                        if (row_end) begin
                            row_q <= '0;
                            if (col_end) begin
                                col_q <= '0;
                                if (oc_end) begin
                                    oc_q   <= '0;
                                    tile_q <= tile_q + 1'b1;
                                end else begin
                                    oc_q <= oc_q + 1'b1;
                                end
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                        if (last_d && tile_end) state_q <= FLUSH;
                    end else if (s.ofm_ready) begin
                        ofm_valid_q <= 1'b0;
                    end
                end
                // final element is still held; done follows its handshake
                FLUSH: if (s.ofm_ready) begin
                    ofm_valid_q <= 1'b0;
                    state_q     <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign collect_done = done_q;
    assign s.stall_req  = stall_q;
    assign s.ofm_valid  = ofm_valid_q;
    assign s.ofm_data   = ofm_data_q;
    assign s.ofm_oc     = ofm_oc_q;
    assign s.ofm_col    = ofm_col_q;
    assign s.ofm_row    = ofm_row_q;
    assign s.ofm_last   = ofm_last_q;
endmodule
